// File: rtl/rf_sync_rx_if.sv
// rtl/rf_sync_rx_if.sv - RF receiver pulse input, enable and packet/status outputs
interface rf_sync_rx_if #(
  parameter int PACKET_SIZE = 24
);
  logic                   rfin;
  logic                   RX;
  logic [PACKET_SIZE-1:0] pkt;
  logic                   pkt_rec;
  logic                   busy;
  logic                   err;

  modport master (output rfin, output RX, input pkt, input pkt_rec, input busy, input err);
  modport slave  (input rfin, input RX, output pkt, output pkt_rec, output busy, output err);
endinterface

// File: rtl/rf_sync_rx.sv
// rtl/rf_sync_rx.sv - pulse-position RF packet receiver with preamble period recovery
module rf_sync_rx #(
  parameter int PACKET_SIZE  = 24,
  parameter int PREAMBLE_LEN = 8,
  parameter int MIN_PERIOD   = 5000,
  parameter int MAX_PERIOD   = 20000
) (
  input  logic        clk,
  input  logic        rst,
  rf_sync_rx_if.slave bus
);
  localparam int CW = $clog2(PREAMBLE_LEN + 1);
  localparam int BW = $clog2(PACKET_SIZE + 1);
  localparam logic [15:0]   MIN_T     = 16'(MIN_PERIOD);
  localparam logic [15:0]   MAX_T     = 16'(MAX_PERIOD);
  localparam logic [CW-1:0] LAST_PRE  = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] FIRST_SUM = CW'(PREAMBLE_LEN - 4);
  localparam logic [BW-1:0] LAST_BIT  = BW'(PACKET_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA} state_t;

  state_t                 r_state, w_state_n;
  logic [2:0]             r_sync;
  logic                   r_pulse;
  logic [15:0]            r_timer;
  logic [CW-1:0]          r_pcnt;
  logic [17:0]            r_sum;
  logic [15:0]            r_period;
  logic [BW-1:0]          r_bcnt;
  logic [PACKET_SIZE-1:0] r_shift;
  logic [PACKET_SIZE-1:0] r_pkt;
  logic                   r_pkt_rec;
  logic                   r_err;

  logic [15:0] w_quarter;
  logic [15:0] w_open;
  logic [16:0] w_close;
  logic [17:0] w_sum_n;
  logic        w_in_range, w_early, w_closed;
  logic        w_tmr_clr, w_tmr_q, w_start, w_pinc, w_lock;
  logic        w_shift, w_bit, w_done, w_err;

  assign w_quarter  = r_period >> 2;
  assign w_open     = r_period - w_quarter;
  assign w_close    = {1'b0, r_period} + {1'b0, w_quarter};
  assign w_sum_n    = r_sum + {2'b00, r_timer};
  assign w_in_range = (r_timer >= MIN_T) && (r_timer <= MAX_T);
  assign w_early    = r_timer < w_open;
  assign w_closed   = {1'b0, r_timer} >= w_close;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_tmr_clr = 1'b0;
    w_tmr_q   = 1'b0;
    w_start   = 1'b0;
    w_pinc    = 1'b0;
    w_lock    = 1'b0;
    w_shift   = 1'b0;
    w_bit     = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.RX && r_pulse) begin
          w_start   = 1'b1;
          w_tmr_clr = 1'b1;
          w_state_n = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (!bus.RX) begin
          w_state_n = S_IDLE;
        end else if (r_pulse) begin
          w_tmr_clr = 1'b1;
          if (!w_in_range) begin
            w_start = 1'b1;
          end else if (r_pcnt == LAST_PRE) begin
            w_lock    = 1'b1;
            w_state_n = S_DATA;
          end else begin
            w_pinc = 1'b1;
          end
        end else if (r_timer > MAX_T) begin
          w_state_n = S_IDLE;
        end
      end
      S_DATA: begin
        if (!bus.RX) begin
          w_err     = 1'b1;
          w_state_n = S_IDLE;
        end else if (r_pulse && w_early) begin
          // an early pulse aborts the packet and is taken as a fresh preamble pulse
          w_err     = 1'b1;
          w_start   = 1'b1;
          w_tmr_clr = 1'b1;
          w_state_n = S_PREAMBLE;
        end else if (r_pulse) begin
          w_shift   = 1'b1;
          w_bit     = 1'b1;
          w_tmr_clr = 1'b1;
        end else if (w_closed) begin
          // re-align the timer as if the missing pulse had arrived on time
          w_shift = 1'b1;
          w_tmr_q = 1'b1;
        end
        if (w_shift && (r_bcnt == LAST_BIT)) begin
          w_done    = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync    <= '0;
      r_pulse   <= 1'b0;
      r_timer   <= '0;
      r_pcnt    <= '0;
      r_sum     <= '0;
      r_period  <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_pkt     <= '0;
      r_pkt_rec <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sync    <= {r_sync[1:0], bus.rfin};
      r_pulse   <= r_sync[1] & ~r_sync[2];
      r_pkt_rec <= w_done;
      r_err     <= w_err;

      if (w_tmr_clr)               r_timer <= '0;
      else if (w_tmr_q)            r_timer <= w_quarter;
      else if (r_timer != 16'hFFFF) r_timer <= r_timer + 16'd1;

      if (w_start) begin
        r_pcnt <= CW'(1);
        r_sum  <= '0;
      end else if (w_pinc || w_lock) begin
        r_pcnt <= r_pcnt + CW'(1);
        if (r_pcnt >= FIRST_SUM) r_sum <= w_sum_n;
      end

      if (w_lock) begin
        r_period <= 16'(w_sum_n >> 2);
        r_bcnt   <= '0;
        r_shift  <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[PACKET_SIZE-2:0], w_bit};
        r_bcnt  <= r_bcnt + BW'(1);
      end

      if (w_done) r_pkt <= {r_shift[PACKET_SIZE-2:0], w_bit};
    end
  end

  assign bus.pkt     = r_pkt;
  assign bus.pkt_rec = r_pkt_rec;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.err     = r_err;
endmodule

// File: tb/tb_rf_sync_rx.sv
// tb/tb_rf_sync_rx.sv - scoreboard bench for rf_sync_rx with scaled pulse periods
`timescale 1ns/1ps
module tb_rf_sync_rx;
  localparam int PS   = 24;
  localparam int PL   = 8;
  localparam int MINP = 40;
  localparam int MAXP = 160;
  localparam int P    = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  rf_sync_rx_if #(.PACKET_SIZE(PS)) bus ();
  rf_sync_rx #(
    .PACKET_SIZE(PS), .PREAMBLE_LEN(PL), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0, err_exp = 0;
  int rec_seen = 0, rec_exp = 0;
  int last_rec_cyc = 0;
  logic [PS-1:0] exp_q[$];
  logic [PS-1:0] model_pkt = '0;
  int sched[$];
  int rise_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: pops the scoreboard whenever the DUT reports a packet
  initial begin
    logic          prev_rec;
    logic [PS-1:0] e;
    prev_rec = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.err) err_seen++;
        if (bus.pkt_rec) begin
          rec_seen++;
          last_rec_cyc = cyc;
          check("pkt_rec_single_cycle", 32'(prev_rec), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pkt_rec_unexpected: got pkt %0h, expected no packet", bus.pkt);
          end else begin
            e = exp_q.pop_front();
            check("pkt", 32'(bus.pkt), 32'(e));
            model_pkt = e;
          end
        end
        prev_rec = bus.pkt_rec;
      end else begin
        prev_rec = 1'b0;
      end
    end
  end

  initial begin
    #(100 * 99000);
    $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int jitter();
    return int'($urandom_range(8, 0)) + int'($urandom_range(8, 0)) - 8;
  endfunction

  task automatic add_payload(input int t0, input logic [PS-1:0] d, input bit jit);
    for (int i = 0; i < PS; i++)
      if (d[PS-1-i]) sched.push_back(t0 + (i + 1) * P + (jit ? jitter() : 0));
  endtask

  task automatic play(output int elapsed);
    int now;
    now = 0;
    rise_cyc.delete();
    foreach (sched[i]) begin
      repeat (sched[i] - now) @(negedge clk);
      bus.rfin = 1'b1;
      rise_cyc.push_back(cyc);
      repeat (4) @(negedge clk);
      bus.rfin = 1'b0;
      now = sched[i] + 4;
    end
    elapsed = now;
  endtask

  task automatic add_preamble();
    sched.delete();
    for (int k = 0; k < PL; k++) sched.push_back(k * P);
  endtask

  task automatic send_packet(input logic [PS-1:0] d, input bit jit);
    int el;
    add_preamble();
    add_payload((PL - 1) * P, d, jit);
    exp_q.push_back(d);
    rec_exp++;
    play(el);
    repeat ((PL + PS + 2) * P - el) @(negedge clk);
  endtask

  initial begin
    int el;
    int lat;
    logic [PS-1:0] d;
    bus.rfin = 1'b0;
    bus.RX   = 1'b1;
    #20 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pkt", 32'(bus.pkt), 32'd0);
    check("reset_pkt_rec", 32'(bus.pkt_rec), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_packet(24'hA5C3F0, 1'b0);
    check("basic_rec_count", 32'(rec_seen), 32'(rec_exp));
    check("basic_no_err", 32'(err_seen), 32'(err_exp));
    check("idle_after_packet", 32'(bus.busy), 32'd0);

    send_packet(24'h000000, 1'b0);
    lat = last_rec_cyc - rise_cyc[PL-1];
    checks++;
    if (lat < 24 * P || lat > 24 * P + P / 2) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles, expected %0d..%0d", lat, 24 * P, 24 * P + P / 2);
    end
    send_packet(24'hFFFFFF, 1'b0);
    check("ones_rec_count", 32'(rec_seen), 32'(rec_exp));

    // spurious pulse shortly after a data bit
    add_preamble();
    sched.push_back(PL * P);
    sched.push_back(PL * P + (3 * P) / 10);
    err_exp++;
    play(el);
    repeat (3 * P) @(negedge clk);
    check("spurious_err", 32'(err_seen), 32'(err_exp));
    check("spurious_no_rec", 32'(rec_seen), 32'(rec_exp));
    check("spurious_pkt_held", 32'(bus.pkt), 32'(model_pkt));
    check("spurious_timeout_idle", 32'(bus.busy), 32'd0);
    send_packet(24'h5A3C96, 1'b0);

    // short preamble interval restarts the count at 1
    sched.delete();
    sched.push_back(0);
    sched.push_back(P);
    sched.push_back(2 * P);
    sched.push_back(2 * P + P / 5);
    play(el);
    repeat (20) @(negedge clk);
    check("short_interval_busy", 32'(bus.busy), 32'd1);
    sched.delete();
    for (int k = 1; k < PL; k++) sched.push_back(k * P - 24);
    add_payload((PL - 1) * P - 24, 24'h3C0FF1, 1'b0);
    exp_q.push_back(24'h3C0FF1);
    rec_exp++;
    play(el);
    repeat ((PS + PL + 2) * P - el) @(negedge clk);
    check("short_interval_no_err", 32'(err_seen), 32'(err_exp));

    // RX drop mid-DATA
    add_preamble();
    sched.push_back(PL * P);
    sched.push_back((PL + 1) * P);
    play(el);
    repeat (P / 2) @(negedge clk);
    bus.RX = 1'b0;
    err_exp++;
    repeat (2) @(negedge clk);
    check("rx_drop_busy", 32'(bus.busy), 32'd0);
    bus.RX = 1'b1;
    repeat (3 * P) @(negedge clk);
    check("rx_drop_err", 32'(err_seen), 32'(err_exp));
    check("rx_drop_pkt_held", 32'(bus.pkt), 32'(model_pkt));

    // asynchronous reset mid-DATA
    add_preamble();
    sched.push_back(PL * P);
    sched.push_back((PL + 1) * P);
    play(el);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_reset_pkt", 32'(bus.pkt), 32'd0);
    check("mid_reset_busy", 32'(bus.busy), 32'd0);
    check("mid_reset_pkt_rec", 32'(bus.pkt_rec), 32'd0);
    check("mid_reset_err", 32'(bus.err), 32'd0);
    model_pkt = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3 * P) @(negedge clk);
    send_packet(24'hC0FFEE, 1'b0);

    for (int n = 0; n < 12; n++) begin
      d = PS'($urandom);
      send_packet(d, 1'b1);
    end

    repeat (P) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_rec_count", 32'(rec_seen), 32'(rec_exp));
    check("final_err_count", 32'(err_seen), 32'(err_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_sync_rx.md
RF_SYNC_RX -- requirements
Module: rf_sync_rx

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 24, payload bits per packet.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 8, count of consecutive 1-pulses forming the preamble.
REQ-003 SHALL have parameter MIN_PERIOD, default 5000, minimum legal pulse interval in clk cycles.
REQ-004 SHALL have parameter MAX_PERIOD, default 20000, maximum legal pulse interval in clk cycles.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have port rfin, input, 1, asynchronous RF pulse input; one pulse means bit 1, no pulse in a bit window means bit 0.
REQ-008 SHALL have port RX, input, 1, receive enable; 0 forces IDLE.
REQ-009 SHALL have port pkt, output, PACKET_SIZE, last received payload, MSB first on air.
REQ-010 SHALL have port pkt_rec, output, 1, one-cycle strobe that pkt was updated.
REQ-011 SHALL have port busy, output, 1, high in PREAMBLE or DATA.
REQ-012 SHALL have port err, output, 1, one-cycle strobe on an aborted packet.

Function
REQ-013 SHALL synchronize rfin with two flops, then detect rising edges; an edge event ("pulse") occurs 3 cycles after the rfin rise.
REQ-014 SHALL keep a 16-bit interval timer, cleared on every accepted pulse, incrementing each cycle, saturating at 65535.
REQ-015 SHALL implement states IDLE, PREAMBLE, DATA.
REQ-016 IDLE: with RX=1, a pulse clears the timer, sets preamble count to 1, and moves to PREAMBLE.
REQ-017 PREAMBLE: a pulse with timer in [MIN_PERIOD, MAX_PERIOD] increments the count.
REQ-018 PREAMBLE: a pulse outside that range restarts the count at 1 with timer cleared, and raises no err.
REQ-019 PREAMBLE: timer exceeding MAX_PERIOD returns to IDLE without err.
REQ-020 SHALL accumulate the intervals ending at preamble pulses PREAMBLE_LEN-3 .. PREAMBLE_LEN (4 intervals) in an 18-bit sum; period = sum >> 2 (truncating).
REQ-021 On the PREAMBLE_LEN-th accepted pulse, SHALL latch period, clear timer and bit count, and enter DATA.
REQ-022 DATA: window opens at period - period/4 and closes at period + period/4, with period/4 = period >> 2.
REQ-023 DATA: pulse inside the window -> shift 1 into the payload register LSB and clear the timer.
REQ-024 DATA: timer reaching window close with no pulse -> shift 0 and set the timer to period/4.
REQ-025 DATA: a pulse before the window opens -> err strobe, payload discarded, restart as in REQ-016 (this pulse counts as preamble pulse 1).
REQ-026 If a pulse and window close occur in the same cycle, the pulse SHALL win (bit 1).
REQ-027 After PACKET_SIZE bits, SHALL copy the shift register to pkt, pulse pkt_rec for exactly one cycle on the next edge, and return to IDLE.
REQ-028 pkt SHALL hold its value until the next completed packet.
REQ-029 RX falling to 0 in PREAMBLE or DATA SHALL return to IDLE next cycle; err pulses only if the state was DATA; pkt is unchanged.

Reset
REQ-030 While rst=0: state IDLE, pkt=0, pkt_rec=0, busy=0, err=0, timer, counters, period, sum and synchronizer all 0.
REQ-031 Reset mid-packet SHALL discard all partial data; the first pulse after release SHALL be treated per REQ-016.

Verification
REQ-032 clk 100 ns, RX=1; 8 pulses every 10000 cycles, then payload 24'hA5C3F0 -> pkt=24'hA5C3F0, one pkt_rec pulse, err never set.
REQ-033 Same packet with interval jitter of ±10% per bit (Gaussian) -> pkt matches the sent payload for 100 random packets.
REQ-034 Payload 24'h000000 -> 24 window-close decisions, pkt=0 and pkt_rec pulses ~240000 cycles after the 8th preamble pulse; payload 24'hFFFFFF -> pkt=24'hFFFFFF.
REQ-035 Spurious pulse 3000 cycles after a DATA bit -> err pulse, no pkt_rec, pkt unchanged; a following valid packet is received correctly.
REQ-036 Preamble pulse interval 2000 cycles (below MIN_PERIOD) -> preamble count restarts at 1, busy stays 1; rst low for 1 cycle mid-DATA -> all outputs 0 immediately.
